// File: rtl/mult_share_ctrl_pkg.sv
// Shared definitions for the multiplier-sharing controller: FSM states,
// default sizing and a width helper.
package mult_share_ctrl_pkg;

    localparam int unsigned DefW       = 4;
    localparam int unsigned DefNreq    = 4;
    localparam int unsigned DefMultLat = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Bits needed to hold 0..v-1, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: scans req upward from ptr (wrapping)
// and reports the first set bit as a one-hot vector and an index.
module mult_share_ctrl_rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PtrW = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic            valid_o,
    output logic [NREQ-1:0] onehot_o,
    output logic [PtrW-1:0] idx_o
);

    // First requester at or after ptr_i in circular order wins.
    always_comb begin
        int unsigned pos;
        pos      = 0;
        valid_o  = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = (32'(ptr_i) + k) % NREQ;
            if (!valid_o && req_i[pos]) begin
                valid_o       = 1'b1;
                onehot_o[pos] = 1'b1;
                idx_o         = PtrW'(pos);
            end
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one sequential multiplier among NREQ requesters: arbitrates
// round-robin, latches the winner's operands, restarts the multiplier,
// waits MULT_LAT cycles and returns the product with a done pulse.
module mult_share_ctrl
    import mult_share_ctrl_pkg::*;
#(
    parameter int unsigned W        = DefW,
    parameter int unsigned NREQ     = DefNreq,
    parameter int unsigned MULT_LAT = DefMultLat
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic [2*W-1:0]    result,
    output logic              busy,
    output logic              mult_rst,
    output logic [W-1:0]      mult_a,
    output logic [W-1:0]      mult_b,
    input  logic [2*W-1:0]    mult_o
);

    localparam int unsigned CntW = clog2_min1(MULT_LAT);
    localparam int unsigned PtrW = clog2_min1(NREQ);

    state_e            state_q;
    logic [PtrW-1:0]   rr_ptr_q;
    logic [CntW-1:0]   cnt_q;
    logic [NREQ-1:0]   win_q;

    logic              arb_valid;
    logic [NREQ-1:0]   arb_onehot;
    logic [PtrW-1:0]   arb_idx;
    logic [PtrW-1:0]   next_ptr;
    logic [W-1:0]      sel_a;
    logic [W-1:0]      sel_b;

    mult_share_ctrl_rr_arbiter #(
        .NREQ (NREQ),
        .PtrW (PtrW)
    ) u_arb (
        .req_i    (req),
        .ptr_i    (rr_ptr_q),
        .valid_o  (arb_valid),
        .onehot_o (arb_onehot),
        .idx_o    (arb_idx)
    );

    // Operand mux for the current winner and the pointer value just past it.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_idx == PtrW'(i)) begin
                sel_a = a_in[i*W +: W];
                sel_b = b_in[i*W +: W];
            end
        end
        next_ptr = (arb_idx == PtrW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
    end

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            win_q    <= '0;
            grant    <= '0;
            done     <= '0;
            result   <= '0;
            busy     <= 1'b0;
            mult_rst <= 1'b1;
            mult_a   <= '0;
            mult_b   <= '0;
        end else begin
            grant <= '0;
            done  <= '0;
            unique case (state_q)
                StIdle: begin
                    if (arb_valid) begin
                        mult_a   <= sel_a;
                        mult_b   <= sel_b;
                        grant    <= arb_onehot;
                        win_q    <= arb_onehot;
                        rr_ptr_q <= next_ptr;
                        busy     <= 1'b1;
                        state_q  <= StClear;
                    end
                end
                StClear: begin
                    // Multiplier has seen one cleared cycle with stable operands.
                    cnt_q    <= CntW'(MULT_LAT - 1);
                    mult_rst <= 1'b0;
                    state_q  <= StRun;
                end
                StRun: begin
                    if (cnt_q == '0) begin
                        mult_rst <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    result  <= mult_o;
                    done    <= win_q;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q  <= StIdle;
                    mult_rst <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
